// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the byte-serial instruction fetch controller
package fetch_pkg;
    localparam int BYTES_PER_INSTR = 4;
    localparam int BYTE_W = 8;
    localparam int CNT_W = $clog2(BYTES_PER_INSTR);
    typedef enum logic [1:0] {IDLE, FETCH, LAST, HOLD} state_t;
    function automatic logic [31:0] wrap_addr(input logic [31:0] a, input int unsigned mem_bytes);
        return a & (mem_bytes - 1);
    endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: memory-read, instruction-delivery and redirect signals of the fetch controller
interface fetch_ctrl_if;
    import fetch_pkg::*;
    logic mem_rd;
    logic [31:0] mem_addr;
    logic [BYTE_W-1:0] mem_rdata;
    logic [BYTES_PER_INSTR*BYTE_W-1:0] instr;
    logic [31:0] instr_pc;
    logic instr_valid;
    logic instr_ready;
    logic redirect;
    logic [31:0] redirect_pc;
    modport master (
        output mem_rd, mem_addr, instr, instr_pc, instr_valid,
        input  mem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  mem_rd, mem_addr, instr, instr_pc, instr_valid,
        output mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_byte_asm.sv
// fetch_byte_asm: places each returning memory byte into its lane of the instruction word
module fetch_byte_asm
    import fetch_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rd_i,
    input  logic                              abort_i,
    input  logic [CNT_W-1:0]                  lane_i,
    input  logic [BYTE_W-1:0]                 rdata_i,
    output logic [BYTES_PER_INSTR*BYTE_W-1:0] instr_o
);
    logic                              pend_q;
    logic [CNT_W-1:0]                  lane_q;
    logic [BYTES_PER_INSTR*BYTE_W-1:0] instr_q;
    // Remember which lane the outstanding read fills; an abort drops the byte due next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 1'b0;
            lane_q  <= '0;
            instr_q <= '0;
        end else begin
            pend_q <= rd_i & ~abort_i;
            lane_q <= lane_i;
            if (pend_q)
                instr_q[lane_q*BYTE_W +: BYTE_W] <= rdata_i;
        end
    end
    assign instr_o = instr_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetches 32-bit little-endian instructions one byte per cycle and hands them out
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 1024
)(
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [31:0]                       pc_q, pc_d;
    logic [31:0]                       ipc_q, ipc_d;
    logic                              valid_q, valid_d;
    logic                              hs;
    logic [BYTES_PER_INSTR*BYTE_W-1:0] asm_instr;
    assign hs = valid_q & bus.instr_ready;
    // Next state; a redirect restarts the fetch from the aligned, wrapped target in any state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        if (bus.redirect) begin
            state_d = FETCH;
            cnt_d   = '0;
            valid_d = 1'b0;
            pc_d    = wrap_addr(bus.redirect_pc & ~32'd3, MEM_BYTES);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end
                FETCH: begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_W'(BYTES_PER_INSTR - 1)) ? LAST : FETCH;
                end
                LAST: begin
                    valid_d = 1'b1;
                    ipc_d   = pc_q;
                    state_d = HOLD;
                end
                HOLD: if (hs) begin
                    valid_d = 1'b0;
                    pc_d    = wrap_addr(pc_q + 32'(BYTES_PER_INSTR), MEM_BYTES);
                    state_d = FETCH;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // State registers; reset discards any fetch in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= wrap_addr(RESET_PC, MEM_BYTES);
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end
    fetch_byte_asm u_asm (
        .clk    (clk),
        .rst    (rst),
        .rd_i   (bus.mem_rd),
        .abort_i(bus.redirect),
        .lane_i (cnt_q),
        .rdata_i(bus.mem_rdata),
        .instr_o(asm_instr)
    );
    assign bus.mem_rd      = ~rst & (state_q == FETCH);
    assign bus.mem_addr    = rst ? '0 : wrap_addr(pc_q + 32'(cnt_q), MEM_BYTES);
    assign bus.instr_valid = ~rst & valid_q;
    assign bus.instr_pc    = rst ? '0 : ipc_q;
    assign bus.instr       = rst ? '0 : asm_instr;
endmodule
